matmul_seq_ctrl: RTL and testbench

- Sequencer for the 2x2 8-bit matrix-multiply datapath.
- Accepts 8 operand bytes on a valid/ready stream in order A00, A01, A10, A11, B00, B01, B10, B11, and writes each one into the datapath through its sel_in/input_val/execute load port.
- Waits a programmable settle time, then reads the 4 products through sel_out.
- Presents each 17-bit product on a registered valid/ready output stream, ordered C00, C01, C10, C11.
- Sits between the GPIO/wishbone glue and the multiplier, replacing manual pin-driven sequencing.

---
 rtl/matmul_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the 2x2 8-bit matrix-multiply datapath: streams 8 operand bytes in,
// waits a settle time, then streams the 4 products out on a registered valid/ready port.
module matmul_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned RES_W         = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_data,
  output logic [1:0]       out_idx,
  output logic             busy,
  output logic             done,
  output logic [2:0]       mm_sel_in,
  output logic [7:0]       mm_input_val,
  output logic             mm_execute,
  output logic [1:0]       mm_sel_out,
  input  logic [RES_W-1:0] mm_result
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StCapture,
    StPresent
  } state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [2:0]         ld_cnt_q, ld_cnt_d;
  logic [1:0]         rd_idx_q, rd_idx_d;
  logic [3:0]         settle_cnt_q, settle_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [RES_W-1:0]   out_data_q, out_data_d;
  logic [1:0]         out_idx_q, out_idx_d;
  logic               done_q, done_d;
  logic               load_fire;

  // abort blocks the beat in the same cycle, so in_ready must see it combinationally
  assign in_ready     = (state_q == StLoad) && !abort;
  assign load_fire    = in_valid && in_ready;
  assign mm_execute   = !load_fire;
  assign mm_sel_in    = (state_q == StLoad) ? ld_cnt_q : 3'd0;
  assign mm_input_val = ((state_q == StLoad) && in_valid) ? in_data : 8'd0;
  assign mm_sel_out   = ((state_q == StCapture) || (state_q == StPresent)) ? rd_idx_q : 2'd0;
  assign busy         = (state_q != StIdle);
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_idx      = out_idx_q;
  assign done         = done_q;

  always_comb begin
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    rd_idx_d     = rd_idx_q;
    settle_cnt_d = settle_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StLoad;
          ld_cnt_d = 3'd0;
        end
      end
      StLoad: begin
        if (load_fire) begin
          ld_cnt_d = ld_cnt_q + 3'd1;
          if (ld_cnt_q == 3'd7) begin
            state_d      = StSettle;
            settle_cnt_d = 4'd0;
          end
        end
      end
      StSettle: begin
        if (settle_cnt_q == SettleLast) begin
          state_d  = StCapture;
          rd_idx_d = 2'd0;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      StCapture: begin
        out_data_d  = mm_result;
        out_idx_d   = rd_idx_q;
        out_valid_d = 1'b1;
        state_d     = StPresent;
      end
      StPresent: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (rd_idx_q == 2'd3) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            rd_idx_d = rd_idx_q + 2'd1;
            state_d  = StCapture;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d     = StIdle;
      ld_cnt_d    = 3'd0;
      rd_idx_d    = 2'd0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      ld_cnt_q     <= 3'd0;
      rd_idx_q     <= 2'd0;
      settle_cnt_q <= 4'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= 2'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_cnt_q     <= ld_cnt_d;
      rd_idx_q     <= rd_idx_d;
      settle_cnt_q <= settle_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench for matmul_seq_ctrl with a behavioural 2x2 datapath model and a
// product scoreboard filled from the operand bytes as they are streamed in.
module tb_matmul_seq_ctrl;

  localparam int RES_W = 17;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = 8'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [RES_W-1:0] out_data;
  logic [1:0]       out_idx;
  logic             busy;
  logic             done;
  logic [2:0]       mm_sel_in;
  logic [7:0]       mm_input_val;
  logic             mm_execute;
  logic [1:0]       mm_sel_out;
  logic [RES_W-1:0] mm_result;

  int errors = 0;
  int checks = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int ov_cnt = 0;

  typedef struct {
    logic [1:0]       idx;
    logic [RES_W-1:0] data;
  } exp_t;
  exp_t sb[$];

  logic [7:0] ops [8];
  logic [7:0] dp_reg [8];

  always #5 clk = ~clk;

  matmul_seq_ctrl #(.SETTLE_CYCLES(2), .RES_W(RES_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_idx      (out_idx),
    .busy         (busy),
    .done         (done),
    .mm_sel_in    (mm_sel_in),
    .mm_input_val (mm_input_val),
    .mm_execute   (mm_execute),
    .mm_sel_out   (mm_sel_out),
    .mm_result    (mm_result)
  );

  // Datapath model: operand register written on every edge with execute low
  always @(posedge clk) if (!mm_execute) dp_reg[mm_sel_in] <= mm_input_val;

  function automatic logic [RES_W-1:0] dot(input logic [7:0] a0, a1, b0, b1);
    return RES_W'(a0) * RES_W'(b0) + RES_W'(a1) * RES_W'(b1);
  endfunction

  always_comb begin
    mm_result = '0;
    case (mm_sel_out)
      2'd0: mm_result = dot(dp_reg[0], dp_reg[1], dp_reg[4], dp_reg[6]);
      2'd1: mm_result = dot(dp_reg[0], dp_reg[1], dp_reg[5], dp_reg[7]);
      2'd2: mm_result = dot(dp_reg[2], dp_reg[3], dp_reg[4], dp_reg[6]);
      default: mm_result = dot(dp_reg[2], dp_reg[3], dp_reg[5], dp_reg[7]);
    endcase
  end

  always @(negedge clk) begin
    if (!mm_execute) beat_cnt++;
    if (done) done_cnt++;
    if (out_valid) ov_cnt++;
  end

  task automatic push_expected(input logic [7:0] b [8]);
    exp_t e;
    e.idx = 2'd0; e.data = b[0] * RES_W'(b[4]) + b[1] * RES_W'(b[6]); sb.push_back(e);
    e.idx = 2'd1; e.data = b[0] * RES_W'(b[5]) + b[1] * RES_W'(b[7]); sb.push_back(e);
    e.idx = 2'd2; e.data = b[2] * RES_W'(b[4]) + b[3] * RES_W'(b[6]); sb.push_back(e);
    e.idx = 2'd3; e.data = b[2] * RES_W'(b[5]) + b[3] * RES_W'(b[7]); sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic start_txn();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Streams the first n operand bytes; optional idle gap before each beat
  task automatic load_bytes(input logic [7:0] b [8], input int n, input bit gaps,
                            input bit start_mid);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mm_execute !== 1'b1) begin
          errors++;
          $display("FAIL gap_execute beat=%0d got=%b want=1", i, mm_execute);
        end
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b[i];
      if (start_mid && i == 3) start = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, mm_execute, mm_sel_in, mm_input_val} !== {1'b1, 1'b0, 3'(i), b[i]}) begin
        errors++;
        $display("FAIL load_beat i=%0d got rdy=%b exe=%b sel=%0d val=%0d want 1 0 %0d %0d",
                 i, in_ready, mm_execute, mm_sel_in, mm_input_val, i, b[i]);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_data  = 8'd0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout got=0 want=1");
    end
  endtask

  task automatic collect(input int stall, input bit start_in_present, input int n);
    bit ok;
    exp_t e;
    logic [RES_W-1:0] held;
    for (int k = 0; k < n; k++) begin
      wait_valid(ok);
      if (!ok) return;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty got=idx%0d/%0d want=none", out_idx, out_data);
      end else begin
        e = sb.pop_front();
        if (out_idx !== e.idx || out_data !== e.data) begin
          errors++;
          $display("FAIL product got=idx%0d/%0d want=idx%0d/%0d", out_idx, out_data,
                   e.idx, e.data);
        end
      end
      held = out_data;
      for (int s = 0; s < stall; s++) begin
        if (start_in_present && s == 0) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== held || mm_sel_out !== 2'(k)) begin
          errors++;
          $display("FAIL stall_hold got=v%b/%0d sel=%0d want=v1/%0d sel=%0d", out_valid,
                   out_data, mm_sel_out, held, k);
        end
      end
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      if (k == 3) begin
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse got=done%b busy%b want=done1 busy0", done, busy);
        end
      end
    end
  endtask

  task automatic full_txn(input int stall, input bit gaps, input bit start_mid,
                          input bit start_in_present);
    int d0;
    d0 = done_cnt;
    beat_cnt = 0;
    push_expected(ops);
    start_txn();
    load_bytes(ops, 8, gaps, start_mid);
    checks++;
    if (beat_cnt != 8) begin
      errors++;
      $display("FAIL beat_count got=%0d want=8", beat_cnt);
    end
    collect(stall, start_in_present, 4);
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_once got=%0d busy=%b want=1 busy=0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_idx, done, in_ready, busy} !== {1'b0, 17'd0, 2'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_out got=v%b d%0d i%0d done%b rdy%b busy%b want=all 0", out_valid,
               out_data, out_idx, done, in_ready, busy);
    end
    checks++;
    if ({mm_execute, mm_sel_in, mm_input_val, mm_sel_out} !== {1'b1, 3'd0, 8'd0, 2'd0}) begin
      errors++;
      $display("FAIL reset_mm got=exe%b si%0d iv%0d so%0d want=exe1 0 0 0", mm_execute,
               mm_sel_in, mm_input_val, mm_sel_out);
    end
  endtask

  task automatic test_basic();
    ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    full_txn(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_max();
    ops = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    full_txn(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    ops = '{8'd9, 8'd14, 8'd200, 8'd3, 8'd17, 8'd250, 8'd1, 8'd77};
    full_txn(5, 1'b1, 1'b0, 1'b0);
    full_txn(5, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    ov_cnt = 0;
    ops = '{8'd40, 8'd41, 8'd42, 8'd43, 8'd44, 8'd45, 8'd46, 8'd47};
    start_txn();
    load_bytes(ops, 3, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'd99;
    abort    = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || mm_execute !== 1'b1) begin
      errors++;
      $display("FAIL abort_block got=rdy%b exe%b want=rdy0 exe1", in_ready, mm_execute);
    end
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ov_cnt != 0) begin
      errors++;
      $display("FAIL abort_idle got=busy%b ov=%0d want=busy0 ov=0", busy, ov_cnt);
    end
    ops = '{8'd2, 8'd0, 8'd0, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1};
    full_txn(1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    ops = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88};
    full_txn(2, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_present();
    bit ok;
    ops = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd9};
    push_expected(ops);
    start_txn();
    load_bytes(ops, 8, 1'b0, 1'b0);
    collect(0, 1'b0, 1);
    wait_valid(ok);
    checks++;
    if (out_idx !== 2'd1) begin
      errors++;
      $display("FAIL c01_idx got=%0d want=1", out_idx);
    end
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || mm_execute !== 1'b1) begin
      errors++;
      $display("FAIL reset_present got=v%b busy%b exe%b want=v0 busy0 exe1", out_valid, busy,
               mm_execute);
    end
    sb.delete();
    ops = '{8'd100, 8'd3, 8'd0, 8'd255, 8'd12, 8'd200, 8'd5, 8'd128};
    full_txn(0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_abort();
    test_start_ignored();
    test_reset_mid_present();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule
